// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_MAX_DIGITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // Saturation pattern: the low n digits set to 9, the remaining digits zero.
  function automatic logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] bcd_all_nines(input int n);
    logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < n) begin
        r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
      end else begin
        r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One-digit double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Add-3 stays inside the nibble; no carry propagates to the next digit.
  always_comb begin
    if (digit_i >= 4'(BCD_ADJ_THRESH)) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one input bit per clock,
// with start/done handshake and saturation when the value exceeds DIGITS digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [SCR_W-1:0] NINES = SCR_W'(bcd_all_nines(DIGITS));

  bcd_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic               sticky_q, sticky_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [SCR_W-1:0]         adj_s;
  logic [SCR_W+BIN_W:0]     shifted_s;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Top bit of shifted_s is the bit leaving the most significant digit.
  assign shifted_s = {adj_s, shreg_q, 1'b0};

  // Next-state logic for the FSM, counter, shift registers and result registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    sticky_d  = sticky_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shreg_d   = binary;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = shifted_s[SCR_W+BIN_W-1:BIN_W];
        shreg_d   = shifted_s[BIN_W-1:0];
        sticky_d  = sticky_q | shifted_s[SCR_W+BIN_W];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bcd_d   = sticky_d ? NINES : scratch_d;
          ovf_d   = sticky_d;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule
